// File: rtl/seven_seg_mux.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// seven_seg_mux
//
// Time-multiplexed driver for two common-anode seven-segment digits that share
// one segment bus. Each frame lights digit 0, blanks, lights digit 1, and
// blanks again:
//
//   DIGIT0 -> BLANK0 -> DIGIT1 -> BLANK1 -> DIGIT0 ...
//
// The blanking slots keep all anodes off while the nibble on s changes. This
// stops the previous digit's value from ghosting onto the next anode.
//
// The digits are double-buffered. A load pulse captures {digit1, digit0} into
// a shadow register. The shadow is committed to the displayed pair only on the
// DIGIT1->BLANK1 edge, so a frame never shows a mix of old and new digits.
//
// Parameters
//   REFRESH_CYCLES  clk cycles each digit is lit per frame (>= 2)
//   BLANK_CYCLES    clk cycles all anodes are off between digits (>= 1)
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   reset       asynchronous, active-low reset (0 = in reset)
//   digit0      hex value for digit 0 (right); sampled when load = 1
//   digit1      hex value for digit 1 (left); sampled when load = 1
//   load        one-cycle request to capture digit0/digit1 into the shadow
//   s           registered nibble to the seven-segment decoder
//   an_n        registered active-low anode enables; [0] = digit0, [1] = digit1
//   pending     1 while a captured shadow value is waiting to be committed
//   frame_tick  one-cycle pulse on the BLANK1->DIGIT0 edge (start of a frame)
// -----------------------------------------------------------------------------
module seven_seg_mux #(
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLANK_CYCLES   = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic       load,
  output logic [3:0] s,
  output logic [1:0] an_n,
  output logic       pending,
  output logic       frame_tick
);

  // One counter serves every slot. It must hold values up to the longer of
  // the two slot lengths minus one.
  localparam int MAX_LIMIT = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES
                                                              : BLANK_CYCLES;
  localparam int CNT_W     = $clog2(MAX_LIMIT);

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // Anode patterns. Both anodes low would light both digits with one nibble.
  // No state drives that pattern, so it can never appear on an_n.
  localparam logic [1:0] AN_OFF    = 2'b11;
  localparam logic [1:0] AN_DIGIT0 = 2'b10;
  localparam logic [1:0] AN_DIGIT1 = 2'b01;

  typedef enum logic [1:0] {
    DIGIT0,
    BLANK0,
    DIGIT1,
    BLANK1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       disp0;
  logic [3:0]       disp1;
  logic [7:0]       shadow;   // {digit1, digit0} captured by the last load

  logic             slot_last;
  logic             commit;
  logic [7:0]       commit_val;

  // The current slot ends this cycle. Lit slots and blank slots have
  // different lengths.
  assign slot_last = (state == DIGIT0 || state == DIGIT1) ? (cnt == REFRESH_LAST)
                                                          : (cnt == BLANK_LAST);

  // A commit happens on the DIGIT1->BLANK1 edge when there is something to
  // commit. A load arriving on that same edge bypasses the shadow. Its value
  // goes straight to the display, so it is not held back a whole frame.
  assign commit     = slot_last && (state == DIGIT1) && (pending || load);
  assign commit_val = load ? {digit1, digit0} : shadow;

  // NOTE: asynchronous assert drops the anodes at once, without waiting for a
  // clock edge. Release must be synchronous to clk; that is arranged upstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BLANK1;
      cnt        <= '0;
      disp0      <= 4'h0;
      disp1      <= 4'h0;
      shadow     <= 8'h00;
      pending    <= 1'b0;
      s          <= 4'h0;
      an_n       <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;

      // NOTE: non-blocking assignments throughout. If the same register is
      // assigned twice in this block, the later assignment wins. The commit
      // branch below relies on that: it clears pending even when a load
      // arrives on the same edge.
      if (load) begin
        shadow  <= {digit1, digit0};
        pending <= 1'b1;
      end

      if (slot_last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end

      // s, an_n and frame_tick are loaded on the edge that enters a state.
      // They therefore change together with the state, never a cycle late.
      if (slot_last) begin
        unique case (state)
          DIGIT0: begin
            state <= BLANK0;
            an_n  <= AN_OFF;
            s     <= disp1;              // pre-set for the coming DIGIT1 slot
          end
          BLANK0: begin
            state <= DIGIT1;
            an_n  <= AN_DIGIT1;
            s     <= disp1;
          end
          DIGIT1: begin
            state <= BLANK1;
            an_n  <= AN_OFF;
            if (commit) begin
              disp1   <= commit_val[7:4];
              disp0   <= commit_val[3:0];
              s       <= commit_val[3:0]; // new digit 0 is pre-set in BLANK1
              pending <= 1'b0;
            end else begin
              s <= disp0;
            end
          end
          BLANK1: begin
            state      <= DIGIT0;
            an_n       <= AN_DIGIT0;
            s          <= disp0;
            frame_tick <= 1'b1;
          end
          default: begin
            state <= BLANK1;
            an_n  <= AN_OFF;
            s     <= disp0;
          end
        endcase
      end
    end
  end

endmodule
